// File: rtl/store_aligner_if.sv
// Store aligner bus: shared memory-width type plus the pipeline-side store
// request channel and the data memory write channel grouped in one interface.
// master = pipeline / memory side (drives requests and mem_ready),
// slave  = store_aligner.
package store_aligner_pkg;

    // Memory access width as carried down the pipeline.
    typedef enum logic [2:0] {
        BYTE      = 3'd0,
        HALFWORD  = 3'd1,
        WORD      = 3'd2,
        UBYTE     = 3'd4,
        UHALFWORD = 3'd5,
        LWCP      = 3'd6
    } mem_data_t;

endpackage

interface store_aligner_if #(
    parameter int BITS           = 32,
    parameter int BYTES_PER_WORD = 4,
    parameter int ADDR_W         = 32
);
    import store_aligner_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic [ADDR_W-1:0]         req_addr;
    logic [BITS-1:0]           req_data;
    mem_data_t                 req_type;

    logic                      mem_wr_en;
    logic                      mem_ready;
    logic [ADDR_W-3:0]         mem_addr;
    logic [BITS-1:0]           mem_wdata;
    logic [BYTES_PER_WORD-1:0] mem_be;

    logic                      st_done;
    logic                      misalign_err;

    modport master (
        output req_valid, req_addr, req_data, req_type, mem_ready,
        input  req_ready, mem_wr_en, mem_addr, mem_wdata, mem_be,
               st_done, misalign_err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_type, mem_ready,
        output req_ready, mem_wr_en, mem_addr, mem_wdata, mem_be,
               st_done, misalign_err
    );

endinterface

// File: rtl/store_aligner.sv
// Store aligner: takes an LSB-justified store from the MEM stage, moves it
// into the right byte lanes, builds byte enables and issues one or two word
// writes to data memory over a ready/valid handshake.
// Optional feature macro: MISALIGNED_SPLIT_EN
//   defined   - stores crossing a word boundary are split into two beats
//   undefined - crossing stores are accepted, dropped, and flagged with a
//               one-cycle misalign_err pulse
module store_aligner
    import store_aligner_pkg::*;
#(
    parameter int BITS           = 32,
    parameter int BYTES_PER_WORD = 4,
    parameter int ADDR_W         = 32
) (
    input  logic           clk,
    input  logic           rst,
    store_aligner_if.slave io_bus
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        ERR
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;

    logic [ADDR_W-3:0]         r_wordAddr;
    logic [BITS-1:0]           r_data;
    logic [BYTES_PER_WORD-1:0] r_mask;
    logic [1:0]                r_off;
`ifdef MISALIGNED_SPLIT_EN
    logic                      r_cross;
    logic [2:0]                w_hiShift;
`endif

    logic                      w_accept;
    logic [1:0]                w_off;
    logic [BYTES_PER_WORD-1:0] w_mask;
    logic [BITS-1:0]           w_laneMask;
    logic                      w_cross;

    logic                      w_wrEn;
    logic [ADDR_W-3:0]         w_memAddr;
    logic [BITS-1:0]           w_wdata;
    logic [BYTES_PER_WORD-1:0] w_be;
    logic                      w_done;
    logic                      w_misalign;

    assign w_off    = io_bus.req_addr[1:0];
    assign w_accept = (r_state == IDLE) && io_bus.req_valid;

    // Decode the request width into a base byte mask, its bit-lane expansion
    // (used to zero the lanes the store does not own) and whether the store
    // spills past the end of its word.
    always_comb begin
        w_mask     = '1;
        w_cross    = 1'b0;
        w_laneMask = '0;
        case (io_bus.req_type)
            BYTE, UBYTE: begin
                w_mask  = BYTES_PER_WORD'(1);
                w_cross = 1'b0;
            end
            HALFWORD, UHALFWORD: begin
                w_mask  = BYTES_PER_WORD'(3);
                w_cross = (w_off == 2'd3);
            end
            default: begin
                w_mask  = '1;
                w_cross = (w_off != 2'd0);
            end
        endcase
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            w_laneMask[8*i +: 8] = {8{w_mask[i]}};
        end
    end

    // State register plus the request fields captured at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wordAddr <= '0;
            r_data     <= '0;
            r_mask     <= '0;
            r_off      <= '0;
`ifdef MISALIGNED_SPLIT_EN
            r_cross    <= 1'b0;
`endif
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_wordAddr <= io_bus.req_addr[ADDR_W-1:2];
                r_data     <= io_bus.req_data & w_laneMask;
                r_mask     <= w_mask;
                r_off      <= w_off;
`ifdef MISALIGNED_SPLIT_EN
                r_cross    <= w_cross;
`endif
            end
        end
    end

    // Next-state: a crossing store either walks through both beats or,
    // without splitting, takes a single error cycle before returning to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (io_bus.req_valid) begin
`ifdef MISALIGNED_SPLIT_EN
                    w_nextState = BEAT0;
`else
                    w_nextState = w_cross ? ERR : BEAT0;
`endif
                end
            end
            BEAT0: begin
                if (io_bus.mem_ready) begin
`ifdef MISALIGNED_SPLIT_EN
                    w_nextState = r_cross ? BEAT1 : IDLE;
`else
                    w_nextState = IDLE;
`endif
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            BEAT1: begin
                if (io_bus.mem_ready) begin
                    w_nextState = IDLE;
                end
            end
`endif
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

`ifdef MISALIGNED_SPLIT_EN
    assign w_hiShift = 3'(BYTES_PER_WORD) - {1'b0, r_off};
`endif

    // Beat outputs are pure functions of state and captured fields, so reset
    // clears them immediately; the low beat shifts data up by the offset,
    // the high beat carries the bytes that spilled over into the next word.
    always_comb begin
        w_wrEn     = 1'b0;
        w_memAddr  = '0;
        w_wdata    = '0;
        w_be       = '0;
        w_done     = 1'b0;
        w_misalign = 1'b0;
        case (r_state)
            BEAT0: begin
                w_wrEn    = 1'b1;
                w_memAddr = r_wordAddr;
                w_wdata   = r_data << {r_off, 3'b000};
                w_be      = r_mask << r_off;
`ifdef MISALIGNED_SPLIT_EN
                w_done    = io_bus.mem_ready && !r_cross;
`else
                w_done    = io_bus.mem_ready;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            BEAT1: begin
                w_wrEn    = 1'b1;
                w_memAddr = r_wordAddr + (ADDR_W-2)'(1);
                w_wdata   = r_data >> {w_hiShift, 3'b000};
                w_be      = r_mask >> w_hiShift;
                w_done    = io_bus.mem_ready;
            end
`else
            ERR: begin
                w_misalign = 1'b1;
            end
`endif
            default: begin
                w_wrEn = 1'b0;
            end
        endcase
    end

    assign io_bus.req_ready    = (r_state == IDLE);
    assign io_bus.mem_wr_en    = w_wrEn;
    assign io_bus.mem_addr     = w_memAddr;
    assign io_bus.mem_wdata    = w_wdata;
    assign io_bus.mem_be       = w_be;
    assign io_bus.st_done      = w_done;
`ifdef MISALIGNED_SPLIT_EN
    assign io_bus.misalign_err = 1'b0;
`else
    assign io_bus.misalign_err = w_misalign;
`endif

endmodule

// File: doc/store_aligner.md
Name: store_aligner

Overview:
- Store-side counterpart to the load-path extender in the data memory module.
- Accepts a store request from the pipeline: byte address, register data and mem_data_t width.
- Shifts the data into the correct byte lanes, generates per-byte write enables and issues one or two word writes to data memory using a ready/valid handshake.
- Sits between the MEM stage and the data memory write port.

Parameters:
- BITS, 32, data word width (from common_params).
- BYTES_PER_WORD, 4, byte lanes per word (from common_params).
- ADDR_W, 32, byte address width; word address is addr[ADDR_W-1:2].

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  store request valid.
- req_ready  out  1  store unit can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_data  in  BITS  unaligned store data, LSB-justified.
- req_type  in  mem_data_t  BYTE/UBYTE, HALFWORD/UHALFWORD or WORD/LWCP.
- mem_wr_en  out  1  memory write beat valid.
- mem_ready  in  1  memory accepts the current beat.
- mem_addr  out  ADDR_W-2  word address of the beat.
- mem_wdata  out  BITS  lane-aligned write data.
- mem_be  out  BYTES_PER_WORD  byte enables.
- st_done  out  1  one-cycle pulse when the final beat of a store is accepted.
- misalign_err  out  1  one-cycle pulse on a dropped crossing store.

Behaviour:
- Reset values: state IDLE, mem_wr_en=0, mem_be=0, mem_addr=0, mem_wdata=0, st_done=0, misalign_err=0. req_ready=1 (it is derived from state IDLE).
- Reset mid-operation returns to IDLE immediately. Any in-flight store is dropped with no st_done.
- Width mapping:
  - UBYTE is treated as BYTE, with base mask 4'b0001.
  - UHALFWORD is treated as HALFWORD, with base mask 4'b0011.
  - WORD, LWCP and all others are treated as WORD, with base mask 4'b1111.
- off = req_addr[1:0].
- Crossing store: a HALFWORD with off=3, or a WORD with off≠0.
- States:
  - IDLE: req_ready=1. On req_valid, latch addr, data, type and off, then go to BEAT0, or take the crossing path described below. req_ready is low in every other state.
  - BEAT0:
    - mem_wr_en=1.
    - mem_addr = latched word address.
    - mem_wdata = (data << 8*off) truncated to BITS.
    - mem_be = (mask << off) truncated to 4 bits.
    - Unused lanes are zero.
    - Outputs hold stable while mem_ready=0.
    - When mem_ready=1: go to BEAT1 if the store is crossing, otherwise pulse st_done and go to IDLE.
  - BEAT1:
    - mem_wr_en=1.
    - mem_addr = word address + 1, modulo 2^(ADDR_W-2), so the top address wraps to 0.
    - mem_wdata = data >> 8*(4-off).
    - mem_be = mask >> (4-off).
    - When mem_ready=1: pulse st_done and go to IDLE.
- Latency: request accepted in cycle N; the first beat is presented in cycle N+1. A non-crossing store completes in N+1 at the earliest; a crossing store in N+2.
- mem_ready is ignored whenever mem_wr_en=0.
- A new request cannot be accepted in the same cycle st_done pulses; the earliest next acceptance is the following cycle, in IDLE.
- mem_wr_en is never asserted with mem_be=0.

Optional Feature:
- Macro: MISALIGNED_SPLIT_EN.
- Defined: crossing stores are split into BEAT0/BEAT1 as above, and misalign_err is tied to 0.
- Undefined:
  - A crossing store is still accepted, but no memory beat is issued.
  - misalign_err pulses for one cycle at N+1, the state returns to IDLE, and st_done is not asserted.
  - BEAT1 logic is not synthesized.

Test Plan:
- BYTE at addr 0x102, data 0xDEADBEEF -> one beat: mem_addr=0x40, mem_wdata=0x00EF0000, mem_be=4'b0100; st_done pulses once.
- HALFWORD at 0x202, data 0x1234ABCD, with mem_ready held low 3 cycles -> mem_wdata=0xABCD0000, be=4'b1100, outputs stable during the stall; st_done on the 4th beat cycle.
- WORD at 0x101, data 0x11223344, MISALIGNED_SPLIT_EN defined:
  - Beat0: addr 0x40, wdata=0x22334400, be=4'b1110.
  - Beat1: addr 0x41, wdata=0x00000011, be=4'b0001.
  - st_done only after beat1.
- Same WORD request at 0x101 with the macro undefined -> no mem_wr_en, misalign_err pulses at N+1, req_ready=1 at N+2.
- Word crossing at byte addr 0xFFFFFFFE (HALFWORD, off=2: no split). Then WORD at 0xFFFFFFFF with split enabled -> beat1 mem_addr wraps to 0x0, be=4'b0111.
- rst asserted while in BEAT1 -> mem_wr_en, mem_be, mem_addr, mem_wdata at 0 and req_ready=1 asynchronously; no st_done; the next request is processed normally.
